tank_input_ctrl: RTL and testbench

//  Parametrised keyboard front end for the tank game: turns raw PS/2 scan-code bytes into per-player direct/moving/shoot.

---
 rtl/tank_input_ctrl_pkg.sv | 44 ++++
 rtl/tank_input_ctrl_if.sv | 16 +
 rtl/tank_input_ctrl_parser.sv | 92 +++++++++
 rtl/tank_input_ctrl.sv | 114 +++++++++++
 tb/tb_tank_input_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/tank_input_ctrl_pkg.sv
// Shared codes, key slots and bundle types
// for the tank game keyboard front end.
package tank_input_ctrl_pkg;

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_DOWN  = 3'd1;
  localparam logic [2:0] DIR_LEFT  = 3'd2;
  localparam logic [2:0] DIR_RIGHT = 3'd3;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_FIRE  = 4;
  localparam int NUM_KEYS  = 5;
  localparam int KEY_W     = 9;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_EXT,
    PS_BRK,
    PS_EXT_BRK
  } ps_state_t;

  typedef struct packed {
    logic       valid;
    logic       brk;
    logic [8:0] key;
  } key_evt_t;

  // Priority up > down > left > right
  function automatic logic [2:0] dir_fallback(
    input logic [3:0] h
  );
    if (h[KEY_UP])        return DIR_UP;
    else if (h[KEY_DOWN]) return DIR_DOWN;
    else if (h[KEY_LEFT]) return DIR_LEFT;
    else                  return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/tank_input_ctrl_if.sv
// Scan byte bus from the PS/2 receiver
// into the tank input controller.
interface tank_input_ctrl_if;
  logic [7:0] scan_code;
  logic       scan_valid;

  modport master (
    output scan_code,
    output scan_valid
  );

  modport slave (
    input scan_code,
    input scan_valid
  );
endinterface

// File: rtl/tank_input_ctrl_parser.sv
// PS/2 set-2 byte parser: E0/F0 prefix
// tracking with abandon timeout.
module tank_input_ctrl_parser
  import tank_input_ctrl_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output key_evt_t   evt
);

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

  ps_state_t state_q, state_d;
  logic [TW-1:0] tmo_q;
  logic tmo_hit;
  key_evt_t evt_d;

  assign tmo_hit = (tmo_q == TW'(PREFIX_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PS_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_q <= '0;
    else if (state_q == PS_IDLE || scan_valid)
      tmo_q <= '0;
    else
      tmo_q <= tmo_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (scan_valid) begin
      unique case (state_q)
        PS_IDLE: begin
          if (scan_code == SC_EXT)
            state_d = PS_EXT;
          else if (scan_code == SC_BRK)
            state_d = PS_BRK;
        end
        PS_EXT: begin
          if (scan_code == SC_BRK)
            state_d = PS_EXT_BRK;
          else
            state_d = PS_IDLE;
        end
        PS_BRK:     state_d = PS_IDLE;
        PS_EXT_BRK: state_d = PS_IDLE;
      endcase
    end else if (state_q != PS_IDLE && tmo_hit) begin
      state_d = PS_IDLE;
    end
  end

  always_comb begin
    evt_d = '0;
    if (scan_valid) begin
      unique case (state_q)
        PS_IDLE: begin
          if (scan_code != SC_EXT &&
              scan_code != SC_BRK)
            evt_d = '{1'b1, 1'b0,
                      {1'b0, scan_code}};
        end
        PS_EXT: begin
          if (scan_code != SC_BRK)
            evt_d = '{1'b1, 1'b0,
                      {1'b1, scan_code}};
        end
        PS_BRK:
          evt_d = '{1'b1, 1'b1,
                    {1'b0, scan_code}};
        PS_EXT_BRK:
          evt_d = '{1'b1, 1'b1,
                    {1'b1, scan_code}};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt <= '0;
    else        evt <= evt_d;
  end

endmodule

// File: rtl/tank_input_ctrl.sv
// Per-player direction arbitration and
// rate-limited auto-fire from key events.
module tank_input_ctrl
  import tank_input_ctrl_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter logic [NUM_PLAYERS*45-1:0] KEYMAP = {
    9'h05A, 9'h174, 9'h16B, 9'h172, 9'h175,
    9'h029, 9'h023, 9'h01C, 9'h01B, 9'h01D
  },
  parameter int FIRE_PERIOD    = 25_000_000,
  parameter int PREFIX_TIMEOUT = 200_000
) (
  input  logic                     clk_100mhz,
  input  logic                     RSTN,
  tank_input_ctrl_if.slave         scan,
  output logic [3*NUM_PLAYERS-1:0] direct,
  output logic [NUM_PLAYERS-1:0]   moving,
  output logic [NUM_PLAYERS-1:0]   shoot
);

  localparam int CW = $clog2(FIRE_PERIOD + 1);

  key_evt_t evt;

  tank_input_ctrl_parser #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
  ) u_parser (
    .clk        (clk_100mhz),
    .rst_n      (RSTN),
    .scan_code  (scan.scan_code),
    .scan_valid (scan.scan_valid),
    .evt        (evt)
  );

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [2:0] dir_q, dir_d;
    logic mov_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic shoot_q, shoot_d;
    logic fire_press, fire_hold;

    always_comb begin
      held_d = held_q;
      dir_d  = dir_q;
      if (evt.valid) begin
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (evt.key ==
              KEYMAP[(p*NUM_KEYS+k)*KEY_W +: KEY_W]) begin
            if (!evt.brk) begin
              if (!held_d[k]) begin
                held_d[k] = 1'b1;
                if (k <= KEY_RIGHT) dir_d = 3'(k);
              end
            end else if (held_d[k]) begin
              held_d[k] = 1'b0;
              if (k <= KEY_RIGHT && dir_d == 3'(k) &&
                  |held_d[KEY_RIGHT:0])
                dir_d = dir_fallback(held_d[KEY_RIGHT:0]);
            end
          end
        end
      end
    end

    assign fire_press = held_d[KEY_FIRE] & ~held_q[KEY_FIRE];
    assign fire_hold  = held_d[KEY_FIRE] &  held_q[KEY_FIRE];

    // Counter always runs down; held key reloads it on expiry
    always_comb begin
      cnt_d   = cnt_q;
      shoot_d = 1'b0;
      if (fire_press) begin
        if (cnt_q == '0) begin
          shoot_d = 1'b1;
          cnt_d   = CW'(FIRE_PERIOD);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end else if (fire_hold) begin
        if (cnt_q <= CW'(1)) begin
          shoot_d = 1'b1;
          cnt_d   = CW'(FIRE_PERIOD);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_100mhz or negedge RSTN) begin
      if (!RSTN) begin
        held_q  <= '0;
        dir_q   <= DIR_UP;
        mov_q   <= 1'b0;
        cnt_q   <= '0;
        shoot_q <= 1'b0;
      end else begin
        held_q  <= held_d;
        dir_q   <= dir_d;
        mov_q   <= |held_d[KEY_RIGHT:0];
        cnt_q   <= cnt_d;
        shoot_q <= shoot_d;
      end
    end

    assign direct[p*3 +: 3] = dir_q;
    assign moving[p]        = mov_q;
    assign shoot[p]         = shoot_q;
  end

endmodule

// File: tb/tb_tank_input_ctrl.sv
// Directed bench for tank_input_ctrl with
// short fire period and prefix timeout.
module tb_tank_input_ctrl;

  logic clk;
  logic rstn;
  logic [5:0] direct;
  logic [1:0] moving;
  logic [1:0] shoot;
  int total;
  int bad;
  logic seen;

  tank_input_ctrl_if bus ();

  tank_input_ctrl #(
    .NUM_PLAYERS    (2),
    .FIRE_PERIOD    (100),
    .PREFIX_TIMEOUT (50)
  ) dut (
    .clk_100mhz (clk),
    .RSTN       (rstn),
    .scan       (bus.slave),
    .direct     (direct),
    .moving     (moving),
    .shoot      (shoot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.scan_code  = b;
    bus.scan_valid = 1'b1;
    @(negedge clk);
    bus.scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rstn  = 1'b0;
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    idle(2);
    chk("rst_dir", direct, 0);
    chk("rst_mov", moving, 0);
    chk("rst_sht", shoot, 0);
    rstn = 1'b1;
    idle(1);

    send(8'h1D);
    chk("up_lat", moving[0], 0);
    idle(1);
    chk("up_dir", direct[2:0], 0);
    chk("up_mov", moving[0], 1);
    chk("up_p1", moving[1], 0);
    send(8'hF0); send(8'h1D); idle(1);
    chk("up_rel_mov", moving[0], 0);
    chk("up_rel_dir", direct[2:0], 0);

    send(8'h1D); send(8'h23); idle(1);
    chk("rt_dir", direct[2:0], 3);
    send(8'hF0); send(8'h23); idle(1);
    chk("fb_up_dir", direct[2:0], 0);
    chk("fb_up_mov", moving[0], 1);
    send(8'hF0); send(8'h1D); idle(1);
    chk("fb_none", moving[0], 0);

    send(8'h1C); send(8'h23); idle(1);
    chk("lr_dir", direct[2:0], 3);
    send(8'hF0); send(8'h23); idle(1);
    chk("fb_left", direct[2:0], 2);
    send(8'hF0); send(8'h1C); idle(1);
    chk("keep_dir", direct[2:0], 2);
    chk("keep_mov", moving[0], 0);

    send(8'h1D); send(8'h1B); idle(1);
    chk("dn_dir", direct[2:0], 1);
    send(8'hF0); send(8'h1D); idle(1);
    chk("noncur_dir", direct[2:0], 1);
    chk("noncur_mov", moving[0], 1);
    send(8'hF0); send(8'h1B); idle(1);
    chk("dn_rel", moving[0], 0);

    send(8'hE0); send(8'h6B); idle(1);
    chk("p1_dir", direct[5:3], 2);
    chk("p1_mov", moving[1], 1);
    chk("p1_p0dir", direct[2:0], 1);
    chk("p1_p0mov", moving[0], 0);
    send(8'hE0); send(8'hF0); send(8'h6B);
    idle(1);
    chk("p1_rel", moving[1], 0);
    send(8'h6B); idle(1);
    chk("noext_mov", moving, 0);
    chk("noext_dir", direct, 6'b010_001);

    send(8'hE0); idle(60);
    send(8'h1D); idle(1);
    chk("tmo_dir", direct[2:0], 0);
    chk("tmo_mov", moving, 2'b01);
    send(8'hF0); send(8'h1D); idle(1);

    send(8'h1D); send(8'h23);
    send(8'h1D); send(8'h1D); send(8'h1D);
    idle(1);
    chk("tm_dir", direct[2:0], 3);
    send(8'hF0); send(8'h1D); idle(1);
    chk("tm_rel_dir", direct[2:0], 3);
    chk("tm_rel_mov", moving[0], 1);
    send(8'hF0); send(8'h23); idle(1);
    for (int i = 0; i < 5; i++) send(8'h1D);
    idle(1);
    chk("tm5_dir", direct[2:0], 0);
    chk("tm5_mov", moving[0], 1);
    send(8'hF0); send(8'h1D); idle(1);
    chk("tm5_rel", moving[0], 0);
    chk("tm5_rdir", direct[2:0], 0);

    send(8'h29);
    chk("fire_lat", shoot, 0);
    idle(1);
    chk("fire_t0", shoot, 2'b01);
    for (int n = 1; n <= 3; n++) begin
      seen = 1'b0;
      repeat (99) begin
        idle(1);
        seen = seen | shoot[0];
      end
      chk("fire_gap", seen, 0);
      idle(1);
      chk("fire_per", shoot, 2'b01);
    end
    seen = 1'b0;
    send(8'hF0); seen = seen | shoot[0];
    send(8'h29); seen = seen | shoot[0];
    repeat (48) begin
      idle(1);
      seen = seen | shoot[0];
    end
    send(8'h29); seen = seen | shoot[0];
    repeat (48) begin
      idle(1);
      seen = seen | shoot[0];
    end
    chk("cool_none", seen, 0);
    idle(1);
    chk("cool_exp", shoot, 2'b01);
    send(8'hF0); send(8'h29);
    idle(120);
    send(8'h29); idle(1);
    chk("fire_fresh", shoot, 2'b01);
    send(8'hF0); send(8'h29); idle(1);

    send(8'h5A); idle(1);
    chk("p1_fire", shoot, 2'b10);
    send(8'hF0); send(8'h5A); idle(1);

    send(8'h1D); send(8'hE0); send(8'h74);
    idle(1);
    chk("pre_mov", moving, 2'b11);
    chk("pre_dir", direct, 6'b011_000);
    send(8'hE0);
    rstn = 1'b0;
    #1;
    chk("mid_dir", direct, 0);
    chk("mid_mov", moving, 0);
    chk("mid_sht", shoot, 0);
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
    send(8'h74); idle(1);
    chk("post_mov", moving, 0);
    chk("post_dir", direct, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
